// File: rtl/breakout_pkg.sv
// breakout_pkg: collision codes, direction bit indices, screen defaults and ball FSM states.
package breakout_pkg;
    localparam logic [1:0] COLL_NONE = 2'b00;
    localparam logic [1:0] COLL_X    = 2'b10;
    localparam logic [1:0] COLL_Y    = 2'b11;
    localparam int DIR_LEFT     = 0;
    localparam int DIR_UP       = 1;
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int BALL_SZ_DEF  = 4;
    localparam int TIMEOUT_DEF  = 63;
    typedef enum logic [2:0] {PARKED, WAIT_TICK, PROBE, WAIT_HIT, COMMIT} state_t;
endpackage

// File: rtl/edge_limits.sv
// edge_limits: screen-edge tests on a proposed ball position; clamps, per-axis flips and lost flag.
module edge_limits
    import breakout_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int BALL_SZ  = BALL_SZ_DEF
) (
    input  logic [10:0] px,
    input  logic [10:0] py,
    input  logic [1:0]  dir,
    input  logic [6:0]  xstep,
    input  logic [6:0]  ystep,
    output logic [9:0]  cx,
    output logic [9:0]  cy,
    output logic        flip_x,
    output logic        flip_y,
    output logic        lost
);
    logic [10:0] old_x, old_y;
    logic hit_l, hit_r, hit_t;
    // The proposed position may have wrapped below zero; adding the step back recovers the old one.
    always_comb begin
        old_x  = px + {4'd0, xstep};
        old_y  = py + {4'd0, ystep};
        hit_l  = dir[DIR_LEFT] && old_x < {4'd0, xstep};
        hit_r  = !dir[DIR_LEFT] && 32'(px) + BALL_SZ > SCREEN_W;
        hit_t  = dir[DIR_UP] && old_y < {4'd0, ystep};
        lost   = !dir[DIR_UP] && 32'(py) + BALL_SZ > SCREEN_H;
        flip_x = hit_l || hit_r;
        flip_y = hit_t;
        cx     = hit_l ? '0 : hit_r ? 10'(SCREEN_W - BALL_SZ) : px[9:0];
        cy     = hit_t ? '0 : py[9:0];
    end
endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame ball stepping; probes the collision checker, applies edges, commits.
module ball_motion_ctrl
    import breakout_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int BALL_SZ  = BALL_SZ_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       serve,
    input  logic       frame_tick,
    input  logic [6:0] xstep,
    input  logic [6:0] ystep,
    output logic       probe_valid,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    input  logic       hit_valid,
    input  logic [1:0] hit_code,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] dir,
    output logic       ball_lost,
    output logic       overrun
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [9:0] PARK_X = 10'(SCREEN_W / 2);
    localparam logic [9:0] PARK_Y = 10'(SCREEN_H - 32);
    localparam logic [1:0] PARK_DIR = 2'b10;
    state_t state, state_n;
    logic [10:0] px, py, nx, ny;
    logic [6:0] xs, ys;
    logic [1:0] code, cdir;
    logic [CW-1:0] cnt;
    logic pend, pend_n, busy, timeout, hx, hy, lost;
    logic [9:0] ex, ey, cx, cy;
    logic efx, efy, elost;
    edge_limits #(
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H),
        .BALL_SZ (BALL_SZ)
    ) u_edge (
        .px    (px),
        .py    (py),
        .dir   (dir),
        .xstep (xs),
        .ystep (ys),
        .cx    (ex),
        .cy    (ey),
        .flip_x(efx),
        .flip_y(efy),
        .lost  (elost)
    );
    assign probe_x = px[9:0];
    assign probe_y = py[9:0];
    assign timeout = cnt == CW'(TIMEOUT);
    always_comb begin
        state_n = state;
        case (state)
            PARKED:    if (serve) state_n = WAIT_TICK;
            WAIT_TICK: if (frame_tick || pend) state_n = PROBE;
            PROBE:     state_n = WAIT_HIT;
            WAIT_HIT:  if (hit_valid || timeout) state_n = COMMIT;
            COMMIT:    state_n = lost ? PARKED : WAIT_TICK;
            default:   state_n = PARKED;
        endcase
    end
    // A brick hit on an axis keeps the old coordinate and overrides any edge clamp on it.
    always_comb begin
        nx     = dir[DIR_LEFT] ? {1'b0, ball_x} - {4'd0, xstep} : {1'b0, ball_x} + {4'd0, xstep};
        ny     = dir[DIR_UP] ? {1'b0, ball_y} - {4'd0, ystep} : {1'b0, ball_y} + {4'd0, ystep};
        hx     = code == COLL_X;
        hy     = code == COLL_Y;
        lost   = elost && !hy;
        cx     = hx ? ball_x : ex;
        cy     = hy ? ball_y : ey;
        cdir   = dir ^ {hy || efy, hx || efx};
        busy   = frame_tick && (state == PROBE || state == WAIT_HIT || state == COMMIT);
        pend_n = state == PARKED ? 1'b0 : state == WAIT_TICK ? pend && frame_tick : pend || busy;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= PARKED;
            px          <= '0;
            py          <= '0;
            xs          <= '0;
            ys          <= '0;
            code        <= COLL_NONE;
            cnt         <= '0;
            pend        <= 1'b0;
            probe_valid <= 1'b0;
            ball_x      <= PARK_X;
            ball_y      <= PARK_Y;
            dir         <= PARK_DIR;
            ball_lost   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            pend        <= pend_n;
            overrun     <= overrun || (busy && pend);
            probe_valid <= state == PROBE;
            ball_lost   <= state == COMMIT && lost;
            cnt         <= state == WAIT_HIT ? cnt + 1'b1 : '0;
            if (state == PROBE) begin
                px <= nx;
                py <= ny;
                xs <= xstep;
                ys <= ystep;
            end
            if (state == WAIT_HIT) code <= hit_valid ? hit_code : COLL_NONE;
            if (state == COMMIT) begin
                ball_x <= lost ? PARK_X : cx;
                ball_y <= lost ? PARK_Y : cy;
                dir    <= lost ? PARK_DIR : cdir;
            end
        end
    end
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: directed frames against a behavioural ball model with probe/commit scoreboards.
module tb_ball_motion_ctrl;
    logic clk = 1'b0;
    logic resetn, serve, frame_tick, hit_valid;
    logic [6:0] xstep, ystep;
    logic [1:0] hit_code, dir;
    logic probe_valid, ball_lost, overrun;
    logic [9:0] probe_x, probe_y, ball_x, ball_y;

    typedef struct {
        int x;
        int y;
        int d;
        int lost;
    } exp_t;
    exp_t pq[$];
    exp_t cq[$];
    int checks = 0;
    int errors = 0;
    int mx, my, ox, pe_x;
    logic [1:0] mdir;
    bit mlost;

    ball_motion_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .serve      (serve),
        .frame_tick (frame_tick),
        .xstep      (xstep),
        .ystep      (ystep),
        .probe_valid(probe_valid),
        .probe_x    (probe_x),
        .probe_y    (probe_y),
        .hit_valid  (hit_valid),
        .hit_code   (hit_code),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .dir        (dir),
        .ball_lost  (ball_lost),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 320;
        my = 448;
        mdir = 2'b10;
    endtask

    task automatic check_reset(input string pre);
        chk({pre, "_ball_x"}, ball_x, 320);
        chk({pre, "_ball_y"}, ball_y, 448);
        chk({pre, "_dir"}, dir, 2);
        chk({pre, "_probe_x"}, probe_x, 0);
        chk({pre, "_probe_y"}, probe_y, 0);
        chk({pre, "_probe_valid"}, probe_valid, 0);
        chk({pre, "_ball_lost"}, ball_lost, 0);
        chk({pre, "_overrun"}, overrun, 0);
    endtask

    // Expected probe and commit for one frame, from the current model and steps.
    task automatic push(input logic [1:0] code);
        int xs, ys, px, py, nx, ny;
        logic l, r, t, b, hx, hy;
        logic [1:0] nd;
        xs = int'(xstep);
        ys = int'(ystep);
        px = mdir[0] ? mx - xs : mx + xs;
        py = mdir[1] ? my - ys : my + ys;
        pq.push_back('{px & 1023, py & 1023, 0, 0});
        ox = mx;
        pe_x = px & 1023;
        hx = code == 2'b10;
        hy = code == 2'b11;
        l = mdir[0] && mx < xs;
        r = !mdir[0] && px + 4 > 640;
        t = mdir[1] && my < ys;
        b = !mdir[1] && py + 4 > 480;
        nx = hx ? mx : l ? 0 : r ? 636 : px;
        ny = hy ? my : t ? 0 : py;
        nd = mdir ^ {hy | t, hx | l | r};
        mlost = b && !hy;
        if (mlost) begin
            cq.push_back('{320, 448, 2, 1});
            model_reset();
        end else begin
            cq.push_back('{nx, ny, int'(nd), 0});
            mx = nx;
            my = ny;
            mdir = nd;
        end
    endtask

    task automatic wait_probe(input int max_cyc);
        exp_t p;
        int n = 0;
        while (probe_valid !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("probe_seen", probe_valid, 1);
        p = pq.pop_front();
        chk("probe_x", probe_x, p.x);
        chk("probe_y", probe_y, p.y);
    endtask

    task automatic check_commit();
        exp_t e;
        e = cq.pop_front();
        chk("commit_x", ball_x, e.x);
        chk("commit_y", ball_y, e.y);
        chk("commit_dir", dir, e.d);
        chk("commit_lost", ball_lost, e.lost);
        if (e.lost != 0) begin
            @(negedge clk);
            chk("lost_once", ball_lost, 0);
        end
    endtask

    task automatic reply(input logic [1:0] code, input int delay);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (i == 0) chk("probe_pulse", probe_valid, 0);
        end
        if (delay >= 0) begin
            hit_valid = 1'b1;
            hit_code = code;
            @(negedge clk);
            hit_valid = 1'b0;
            @(negedge clk);
        end else begin
            repeat (64) @(negedge clk);
            chk("timeout_early_x", ball_x, ox);
            chk("timeout_hold_px", probe_x, pe_x);
            @(negedge clk);
        end
        check_commit();
    endtask

    task automatic frame(input logic [1:0] code, input int delay);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        push(code);
        wait_probe(8);
        reply(code, delay);
    endtask

    task automatic expect_no_probe(input string tag);
        int seen = 0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (probe_valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        resetn = 1'b0;
        serve = 1'b0;
        frame_tick = 1'b0;
        hit_valid = 1'b0;
        hit_code = 2'b00;
        xstep = 7'd2;
        ystep = 7'd2;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("rst");
        resetn = 1'b1;
        @(negedge clk);
        expect_no_probe("parked_tick_ignored");
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
        frame(2'b00, 0);
        hit_valid = 1'b1;
        hit_code = 2'b11;
        @(negedge clk);
        hit_valid = 1'b0;
        frame(2'b00, 3);
        xstep = 7'd127;
        ystep = 7'd0;
        for (int i = 0; i < 6 && !mdir[0]; i++) frame(2'b00, 0);
        chk("right_edge_x", ball_x, 636);
        xstep = 7'd5;
        ystep = 7'd3;
        frame(2'b11, 0);
        frame(2'b10, 0);
        frame(2'b00, -1);
        frame(2'b11, 0);
        xstep = 7'd127;
        ystep = 7'd127;
        for (int i = 0; i < 10 && mdir != 2'b00; i++) frame(2'b00, 0);
        xstep = 7'd0;
        mlost = 1'b0;
        for (int i = 0; i < 8 && !mlost; i++) frame(2'b00, 0);
        chk("lost_reached", ball_y, 448);
        chk("overrun_clear", overrun, 0);
        expect_no_probe("lost_parked");
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
        xstep = 7'd2;
        ystep = 7'd2;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        push(2'b00);
        wait_probe(8);
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
        chk("overrun_set", overrun, 1);
        reply(2'b00, 0);
        push(2'b00);
        wait_probe(3);
        chk("overrun_sticky", overrun, 1);
        resetn = 1'b0;
        #1;
        check_reset("midprobe_rst");
        pq.delete();
        cq.delete();
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        expect_no_probe("post_reset_parked");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
